// File: rtl/sel_mem_arb.sv
// sel_mem_arb: round-robin arbiter that loads the winner's bank id into the
// shared sel_mem register, lets it settle for a cycle, then grants the bank
// for a bounded burst. All outputs come straight from flops.
module sel_mem_arb #(
  parameter int NUM_REQ   = 3,
  parameter int MAX_BURST = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [4*NUM_REQ-1:0]   bank_id,
  output logic [NUM_REQ-1:0]     gnt,
  output logic                   sel_en,
  output logic [3:0]             sel_data,
  output logic                   busy
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_ACTIVE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [IW-1:0]        r_ptr;
  logic [IW-1:0]        r_win;
  logic [CW-1:0]        r_cnt;
  logic [NUM_REQ-1:0]   r_gnt;
  logic                 r_sel_en;
  logic [3:0]           r_sel_data;
  logic                 r_busy;

  logic                 w_found;
  logic [IW-1:0]        w_pick;
  logic [IW-1:0]        w_idx;
  logic [3:0]           w_bank;
  logic                 w_win_req;
  logic                 w_last;
  logic                 w_to_idle;
  logic [IW-1:0]        w_ptr_next;
  logic [NUM_REQ-1:0]   w_win_onehot;

  // Round-robin scan: walk offsets from the highest down so the requester
  // closest to r_ptr is the last one written and therefore wins.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    w_bank  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int s;
      s = int'(r_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      w_idx = IW'(s);
      if (req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
        w_bank  = bank_id[{w_idx, 2'b00} +: 4];
      end
    end
  end

  assign w_win_req    = req[r_win];
  assign w_last       = (r_cnt == CW'(MAX_BURST - 1));
  assign w_ptr_next   = (r_win == IW'(NUM_REQ - 1)) ? '0 : r_win + IW'(1);
  assign w_win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_win;
  assign w_to_idle    = (r_state != S_IDLE) && (w_next == S_IDLE);

  // Next-state logic: dropping the winner's request aborts from any busy state.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_found) w_next = S_LOAD;
      S_LOAD:   w_next = w_win_req ? S_SETTLE : S_IDLE;
      S_SETTLE: w_next = w_win_req ? S_ACTIVE : S_IDLE;
      S_ACTIVE: if (!w_win_req || w_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Arbitration capture, pointer/counter upkeep, and registered outputs
  // decoded from the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_cnt      <= '0;
      r_gnt      <= '0;
      r_sel_en   <= 1'b0;
      r_sel_data <= '0;
      r_busy     <= 1'b0;
    end else begin
      if (r_state == S_IDLE && w_found) begin
        r_win      <= w_pick;
        r_sel_data <= w_bank;
      end
      if (w_to_idle) begin
        r_ptr <= w_ptr_next;
        r_cnt <= '0;
      end else if (r_state == S_ACTIVE) begin
        r_cnt <= r_cnt + CW'(1);
      end
      r_sel_en <= (w_next == S_LOAD);
      r_busy   <= (w_next != S_IDLE);
      r_gnt    <= (w_next == S_ACTIVE) ? w_win_onehot : '0;
    end
  end

  assign gnt      = r_gnt;
  assign sel_en   = r_sel_en;
  assign sel_data = r_sel_data;
  assign busy     = r_busy;

endmodule
